// File: rtl/flatten_stream_if.sv
// Pixel-in / feature-out bundle of flatten_stream; slave is the block side, master the producer/consumer side.
interface flatten_stream_if #(
  parameter int CH        = 16,
  parameter int DATA_BITS = 8
);
  logic                      in_valid;
  logic [CH*DATA_BITS-1:0]   in_data;
  logic                      in_ready;
  logic                      feat_valid;
  logic [DATA_BITS-1:0]      feat_data;
  logic                      frame_done;
  logic                      err_drop;

  modport master (
    output in_valid, in_data,
    input  in_ready, feat_valid, feat_data, frame_done, err_drop
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, feat_valid, feat_data, frame_done, err_drop
  );
endinterface

// File: rtl/flatten_stream.sv
// Buffers one HxW frame of CH-wide pixels, then streams H*W*CH bytes in ORDER-selected flatten order.
// First element 2 cycles after the last pixel; no output backpressure, input stalls (in_ready=0) while draining.
module flatten_stream #(
  parameter int H         = 14,
  parameter int W         = 14,
  parameter int CH        = 16,
  parameter int DATA_BITS = 8,
  parameter int ORDER     = 0
) (
  input  logic             clk,
  input  logic             rst,
  flatten_stream_if.slave  bus
);
  localparam int NPIX = H * W;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int WORD = CH * DATA_BITS;
  localparam logic [PW-1:0] P_LAST = PW'(NPIX - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CH - 1);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         p_q, p_d;
  logic [CW-1:0]         c_q, c_d;
  logic [CW-1:0]         rd_c_q, rd_c_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  rd_last_q, rd_last_d;
  logic                  feat_valid_q, feat_valid_d;
  logic [DATA_BITS-1:0]  feat_data_q, feat_data_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_drop_q, err_drop_d;

  logic [WORD-1:0]       mem [NPIX];
  logic [WORD-1:0]       rd_word_q;
  logic [DATA_BITS-1:0]  sel_byte;

  logic                  in_ready;
  logic                  rd_en;
  logic                  wr_en;
  logic                  rd_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (wr_en && (wr_ptr_q == P_LAST)) state_d = DRAIN;
      DRAIN:   if (rd_last) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready = (state_q == FILL);
    rd_en    = (state_q == DRAIN);
  end

  assign wr_en   = in_ready & bus.in_valid;
  assign rd_last = rd_en && (p_q == P_LAST) && (c_q == C_LAST);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == P_LAST) ? '0 : wr_ptr_q + 1'b1;

    p_d = p_q;
    c_d = c_q;
    if (rd_en) begin
      if (ORDER == 0) begin
        if (p_q == P_LAST) begin
          p_d = '0;
          c_d = (c_q == C_LAST) ? '0 : c_q + 1'b1;
        end else begin
          p_d = p_q + 1'b1;
        end
      end else begin
        if (c_q == C_LAST) begin
          c_d = '0;
          p_d = (p_q == P_LAST) ? '0 : p_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
    end

    rd_vld_d  = rd_en;
    rd_last_d = rd_last;
    rd_c_d    = rd_en ? c_q : rd_c_q;
  end

  // The channel index travels with the word read so the byte select lines up one cycle later.
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < CH; i++) begin
      if (rd_c_q == CW'(i)) sel_byte = rd_word_q[i*DATA_BITS +: DATA_BITS];
    end
    feat_valid_d = rd_vld_q;
    frame_done_d = rd_last_q;
    feat_data_d  = rd_vld_q ? sel_byte : feat_data_q;
    err_drop_d   = err_drop_q | (bus.in_valid & ~in_ready);
  end

  // Plain synchronous RAM: one write port (fill), one registered read port (drain).
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= bus.in_data;
    if (rd_en) rd_word_q <= mem[p_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      p_q          <= '0;
      c_q          <= '0;
      rd_c_q       <= '0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      feat_valid_q <= 1'b0;
      feat_data_q  <= '0;
      frame_done_q <= 1'b0;
      err_drop_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      p_q          <= p_d;
      c_q          <= c_d;
      rd_c_q       <= rd_c_d;
      rd_vld_q     <= rd_vld_d;
      rd_last_q    <= rd_last_d;
      feat_valid_q <= feat_valid_d;
      feat_data_q  <= feat_data_d;
      frame_done_q <= frame_done_d;
      err_drop_q   <= err_drop_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.feat_valid = feat_valid_q;
  assign bus.feat_data  = feat_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err_drop   = err_drop_q;
endmodule
